// File: rtl/prbs_vec_gen_pkg.sv
// Shared types and the xorshift32 step used by the vector source and its checkers.
package prbs_vec_gen_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } prbs_state_t;

  // xorshift32 has 0 as a fixed point, so a zero seed is replaced by this value.
  localparam logic [31:0] PRBS_ZERO_SEED_SUB = 32'd1;

  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/prbs_unroll.sv
// Combinational NB-step xorshift32 unroll: lane k is the low byte after step k+1.
module prbs_unroll
  import prbs_vec_gen_pkg::*;
#(
  parameter int unsigned NB = 8
) (
  input  logic [31:0]        state,
  output logic [NB-1:0][7:0] bytes,
  output logic [31:0]        next
);

  logic [31:0] chain [NB+1];

  assign chain[0] = state;

  for (genvar k = 0; k < NB; k++) begin : g_step
    assign chain[k+1] = xorshift32_step(chain[k]);
    assign bytes[k]   = chain[k+1][7:0];
  end

  assign next = chain[NB];

endmodule

// File: rtl/prbs_vec_gen.sv
// Pseudo-random byte-vector source over valid/ready beats.
// Optional running checksum port o_csum when PRBS_VEC_GEN_CSUM_EN is defined.
module prbs_vec_gen
  import prbs_vec_gen_pkg::*;
#(
  parameter int DAT_BITS = 64,
  parameter int LEN_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [LEN_BITS-1:0] i_len,
  input  logic [31:0]         i_seed,
  output logic                o_busy,
  output logic                o_done,
  output logic [DAT_BITS-1:0] o_dat,
  output logic                o_val,
  input  logic                i_rdy,
  output logic                o_sop,
  output logic                o_eop,
`ifdef PRBS_VEC_GEN_CSUM_EN
  output logic [((DAT_BITS/8) > 1 ? $clog2(DAT_BITS/8) : 1)-1:0] o_mod,
  output logic [31:0]         o_csum
`else
  output logic [((DAT_BITS/8) > 1 ? $clog2(DAT_BITS/8) : 1)-1:0] o_mod
`endif
);

  localparam int unsigned NB       = DAT_BITS / 8;
  localparam int unsigned MOD_BITS = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LEN_BITS-1:0] NB_L  = LEN_BITS'(NB);
  localparam logic [LEN_BITS-1:0] ONE_L = LEN_BITS'(1);
  localparam logic [LEN_BITS-1:0] TWO_L = LEN_BITS'(2);

  prbs_state_t state_q, state_n;
  logic [31:0]          x_q, x_n;
  logic [LEN_BITS-1:0]  rem_q, rem_n;
  logic [MOD_BITS-1:0]  mod_last_q, mod_last_n;
  logic [DAT_BITS-1:0]  dat_q, dat_n;
  logic                 val_q, val_n, sop_q, sop_n, eop_q, eop_n;
  logic                 busy_q, busy_n, done_q, done_n;
  logic [MOD_BITS-1:0]  mod_q, mod_n;

  logic [31:0]          seed_eff, u_state, u_next;
  logic [NB-1:0][7:0]   u_bytes;
  logic [LEN_BITS-1:0]  len_beats, len_rem;
  logic [MOD_BITS-1:0]  len_mod, beat_mod;
  logic                 beat_last;
  logic [DAT_BITS-1:0]  beat_dat;

  assign seed_eff  = (i_seed == '0) ? PRBS_ZERO_SEED_SUB : i_seed;
  assign u_state   = (state_q == IDLE) ? seed_eff : x_q;
  assign len_rem   = i_len % NB_L;
  assign len_beats = (i_len / NB_L) + LEN_BITS'(len_rem != '0);
  assign len_mod   = (len_rem == '0) ? '0 : MOD_BITS'(NB_L - len_rem);

  prbs_unroll #(.NB(NB)) u_unroll (
    .state (u_state),
    .bytes (u_bytes),
    .next  (u_next)
  );

  // The same unroll serves the first beat (from the seed) and every later beat.
  always_comb begin
    beat_last = 1'b0;
    beat_mod  = '0;
    if (state_q == IDLE) begin
      beat_last = (len_beats == ONE_L);
      beat_mod  = len_mod;
    end else begin
      beat_last = (rem_q == TWO_L);
      beat_mod  = mod_last_q;
    end
    for (int unsigned k = 0; k < NB; k++) begin
      beat_dat[k*8 +: 8] = (!beat_last || (k < NB - 32'(beat_mod))) ? u_bytes[k] : 8'h00;
    end
  end

`ifdef PRBS_VEC_GEN_CSUM_EN
  localparam int unsigned NW = (DAT_BITS + 31) / 32;
  logic [NW*32-1:0] dat_pad;
  logic [31:0]      dat_fold, csum_q, csum_n;

  always_comb begin
    dat_pad                 = '0;
    dat_pad[DAT_BITS-1:0]   = dat_q;
    dat_fold                = '0;
    for (int unsigned w = 0; w < NW; w++) dat_fold ^= dat_pad[w*32 +: 32];
  end

  assign o_csum = csum_q;
`endif

  always_comb begin
    state_n    = state_q;
    x_n        = x_q;
    rem_n      = rem_q;
    mod_last_n = mod_last_q;
    dat_n      = dat_q;
    val_n      = val_q;
    sop_n      = sop_q;
    eop_n      = eop_q;
    mod_n      = mod_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
`ifdef PRBS_VEC_GEN_CSUM_EN
    csum_n     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
`ifdef PRBS_VEC_GEN_CSUM_EN
          csum_n = '0;
`endif
          if (i_len == '0) begin
            done_n = 1'b1;
          end else begin
            state_n    = SEND;
            x_n        = u_next;
            rem_n      = len_beats;
            mod_last_n = len_mod;
            dat_n      = beat_dat;
            val_n      = 1'b1;
            sop_n      = 1'b1;
            eop_n      = beat_last;
            mod_n      = beat_last ? len_mod : '0;
            busy_n     = 1'b1;
          end
        end
      end
      SEND: begin
        if (val_q && i_rdy) begin
`ifdef PRBS_VEC_GEN_CSUM_EN
          csum_n = csum_q ^ dat_fold;
`endif
          if (eop_q) begin
            state_n = IDLE;
            dat_n   = '0;
            val_n   = 1'b0;
            sop_n   = 1'b0;
            eop_n   = 1'b0;
            mod_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            x_n   = u_next;
            rem_n = rem_q - ONE_L;
            dat_n = beat_dat;
            sop_n = 1'b0;
            eop_n = beat_last;
            mod_n = beat_last ? mod_last_q : '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      rem_q      <= '0;
      mod_last_q <= '0;
      dat_q      <= '0;
      val_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      mod_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PRBS_VEC_GEN_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_n;
      x_q        <= x_n;
      rem_q      <= rem_n;
      mod_last_q <= mod_last_n;
      dat_q      <= dat_n;
      val_q      <= val_n;
      sop_q      <= sop_n;
      eop_q      <= eop_n;
      mod_q      <= mod_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
`ifdef PRBS_VEC_GEN_CSUM_EN
      csum_q     <= csum_n;
`endif
    end
  end

  assign o_dat  = dat_q;
  assign o_val  = val_q;
  assign o_sop  = sop_q;
  assign o_eop  = eop_q;
  assign o_mod  = mod_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_prbs_vec_gen.sv
// Bench for prbs_vec_gen: byte-stream reference model plus per-cycle compare.
// Covers the PRBS_VEC_GEN_CSUM_EN checksum when that macro is defined.
module tb_prbs_vec_gen;

  localparam int DAT_BITS = 64;
  localparam int LEN_BITS = 16;
  localparam int NB       = DAT_BITS / 8;

  logic                clk = 1'b0;
  logic                i_rst, i_start, i_rdy;
  logic [LEN_BITS-1:0] i_len;
  logic [31:0]         i_seed;
  logic                o_busy, o_done, o_val, o_sop, o_eop;
  logic [DAT_BITS-1:0] o_dat;
  logic [2:0]          o_mod;
`ifdef PRBS_VEC_GEN_CSUM_EN
  logic [31:0]         o_csum;
`endif

  always #5 clk = ~clk;

  prbs_vec_gen #(.DAT_BITS(DAT_BITS), .LEN_BITS(LEN_BITS)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_len   (i_len),
    .i_seed  (i_seed),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_dat   (o_dat),
    .o_val   (o_val),
    .i_rdy   (i_rdy),
    .o_sop   (o_sop),
    .o_eop   (o_eop),
`ifdef PRBS_VEC_GEN_CSUM_EN
    .o_mod   (o_mod),
    .o_csum  (o_csum)
`else
    .o_mod   (o_mod)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Reference model: queue of beats still to be delivered by the current vector.
  logic [DAT_BITS-1:0] q_dat[$];
  bit                  q_sop[$], q_eop[$];
  int                  q_mod[$];
  bit                  m_done = 1'b0;
  logic [31:0]         m_csum = '0;
  bit                  mon_en = 1'b0;
  bit                  rnd_rdy = 1'b0;

  task automatic build(input logic [31:0] seed, input int len);
    logic [31:0] x;
    logic [DAT_BITS-1:0] beat;
    int nbeats;
    x = (seed == 0) ? 32'd1 : seed;
    nbeats = (len + NB - 1) / NB;
    for (int b = 0; b < nbeats; b++) begin
      beat = '0;
      for (int k = 0; k < NB; k++) begin
        x = xs(x);
        if (b * NB + k < len) beat[k*8 +: 8] = x[7:0];
      end
      q_dat.push_back(beat);
      q_sop.push_back(b == 0);
      q_eop.push_back(b == nbeats - 1);
      q_mod.push_back((b == nbeats - 1) ? (NB - len % NB) % NB : 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("val", o_val, q_dat.size() > 0);
      check("busy", o_busy, q_dat.size() > 0);
      check("done", o_done, m_done);
      if (q_dat.size() > 0) begin
        check("dat", o_dat, q_dat[0]);
        check("sop", o_sop, q_sop[0]);
        check("eop", o_eop, q_eop[0]);
        check("mod", o_mod, q_mod[0]);
      end else begin
        check("mod_idle", o_mod, 0);
      end
`ifdef PRBS_VEC_GEN_CSUM_EN
      if (m_done) check("csum", o_csum, m_csum);
`endif
      m_done = 1'b0;
      if (i_rst) begin
        q_dat.delete(); q_sop.delete(); q_eop.delete(); q_mod.delete();
        m_csum = '0;
      end else if (q_dat.size() > 0) begin
        if (i_rdy) begin
          m_csum ^= q_dat[0][31:0] ^ q_dat[0][63:32];
          void'(q_dat.pop_front()); void'(q_sop.pop_front());
          void'(q_eop.pop_front()); void'(q_mod.pop_front());
          if (q_dat.size() == 0) m_done = 1'b1;
        end
      end else if (i_start) begin
        m_csum = '0;
        if (i_len == 0) m_done = 1'b1;
        else build(i_seed, int'(i_len));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) i_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      if (o_done === 1'b1) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic start(input logic [31:0] seed, input int len);
    i_start = 1'b1;
    i_len   = LEN_BITS'(len);
    i_seed  = seed;
    tick();
    i_start = 1'b0;
  endtask

  logic [DAT_BITS-1:0] exp0;
  logic [31:0]         seed_r, x;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_rdy = 1'b1; i_len = '0; i_seed = '0;
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_val", o_val, 0);  check("rst_dat", o_dat, 0);
    check("rst_busy", o_busy, 0); check("rst_done", o_done, 0);
    check("rst_sop", o_sop, 0);  check("rst_eop", o_eop, 0);
    check("rst_mod", o_mod, 0);
    i_rst = 1'b0;
    tick();

    // Model pins against hand-computed xorshift32 values.
    check("xs_1", xs(32'd1), 32'h0004_2021);
    check("xs_2", xs(xs(32'd1)), 32'h0408_0601);

    // Reference bytes: seed 1, len 2.
    start(32'd1, 2);
    check("ref_model", q_dat[0], 64'h0121);
    check("ref_dat", o_dat, 64'h0000_0000_0000_0121);
    check("ref_sop", o_sop, 1); check("ref_eop", o_eop, 1);
    check("ref_mod", o_mod, 6);
    tick();
    check("ref_done", o_done, 1); check("ref_busy", o_busy, 0);
    tick();
    check("ref_done_pulse", o_done, 0);

    // Multi-beat, zero seed substitutes 1.
    start(32'd0, 20);
    check("mb_beats", q_dat.size(), 3);
    check("mb_mod", q_mod[2], 4);
    wait_done("mb");

    // Backpressure.
    rnd_rdy = 1'b1;
    start($urandom, 64);
    wait_done("bp");

    // Zero length.
    rnd_rdy = 1'b0; i_rdy = 1'b1;
    tick();
    start($urandom, 0);
    check("zl_done", o_done, 1); check("zl_val", o_val, 0);
    tick();

    // Start during SEND is ignored.
    rnd_rdy = 1'b1;
    start($urandom, 24);
    i_start = 1'b1; i_len = 16'd200; i_seed = 32'h1234_5678;
    tick(); tick();
    i_start = 1'b0;
    wait_done("ign");

    // Reset mid-vector after beat 1 of 4.
    rnd_rdy = 1'b0; i_rdy = 1'b1;
    tick();
    seed_r = $urandom;
    start(seed_r, 32);
    exp0 = q_dat[0];
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("mr_val", o_val, 0); check("mr_dat", o_dat, 0);
    check("mr_busy", o_busy, 0); check("mr_sop", o_sop, 0);
    check("mr_eop", o_eop, 0); check("mr_mod", o_mod, 0);
    tick();
    check("mr_nodone", o_done, 0);
    start(seed_r, 32);
    check("mr_beat0", o_dat, exp0);
    wait_done("mr");

    // Checksum of a single full beat from seed 1.
    start(32'd1, 8);
    wait_done("cs");
`ifdef PRBS_VEC_GEN_CSUM_EN
    exp0 = '0; x = 32'd1;
    for (int k = 0; k < NB; k++) begin x = xs(x); exp0[k*8 +: 8] = x[7:0]; end
    check("cs_val", o_csum, exp0[31:0] ^ exp0[63:32]);
`endif

    // Random vectors, random backpressure.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      start(($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, int'($urandom_range(0, 100)));
      if (o_done !== 1'b1) wait_done("rnd");
    end
    rnd_rdy = 1'b0; i_rdy = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prbs_vec_gen.md
# prbs_vec_gen

Synthesizable pseudo-random vector source: produces a stream of `i_len` pseudo-random bytes from a 32-bit seed and emits them as `DAT_BITS`-wide beats over a valid/ready interface. It is the transmit end of the team's randomized-vector test flow. It feeds the Montgomery multiplier datapath and the on-chip result checkers in hardware self-test, where the simulation-only random vector helpers are unavailable. Byte order and length semantics match the simulation vector convention: byte 0 is generated first and sits at bits [7:0].

## Interface
- `DAT_BITS`, 64: output beat width; multiple of 8, 8..512.
- `LEN_BITS`, 16: width of byte-length input.
- `NB` (localparam), `DAT_BITS/8`: bytes per beat.
- `MOD_BITS` (localparam), `$clog2(NB)` (min 1).

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_start`, in, 1: start request, sampled in IDLE only.
- `i_len`, in, LEN_BITS: vector length in bytes, latched on accepted start.
- `i_seed`, in, 32: LFSR seed, latched on accepted start.
- `o_busy`, out, 1: high from accepted start until the last beat is accepted.
- `o_done`, out, 1: one-cycle pulse after completion.
- `o_dat`, out, DAT_BITS: beat data.
- `o_val`, out, 1: beat valid.
- `i_rdy`, in, 1: downstream ready.
- `o_sop`, out, 1: first beat.
- `o_eop`, out, 1: last beat.
- `o_mod`, out, MOD_BITS: count of unused top bytes on the eop beat; 0 otherwise.
- `o_csum`, out, 32: only with `PRBS_VEC_GEN_CSUM_EN`; see Configuration.

## Operation
- **Generator:** xorshift32. Each step is `x^=x<<13; x^=x>>17; x^=x<<5`. A byte is the low 8 bits of x after its step. One beat needs NB steps, unrolled combinationally. Lane k holds the byte from step k+1 relative to the beat start.
- **Seed handling:** a seed of 0 is replaced by 1, because xorshift never leaves 0.
- **States:** IDLE, SEND.
  - IDLE with `i_start=1`:
    - `i_len>0`: latch len and seed, compute the first beat, go to SEND.
    - `i_len==0`: stay in IDLE, emit no beats, pulse `o_done` next cycle.
  - SEND: present a beat. On `o_val&&i_rdy`:
    - Advance the state by NB steps.
    - Decrement the remaining beat count.
    - If this is the eop beat, go to IDLE and pulse `o_done` in the next cycle.
- **Beat count:** ceil(len/NB). On the eop beat, `o_mod=(NB-len%NB)%NB`, and unused bytes are driven to 0. Generator steps are still consumed for those lanes, but they are not output.
- **Ignored starts:** `i_start` in SEND is ignored; no queueing.
- **Single-beat vector:** when len≤NB, `o_sop` and `o_eop` assert together.

## Timing
- **Reset:** on the next edge with `i_rst=1`, all outputs go to 0 and the state goes to IDLE. This also applies mid-vector: the beat in flight is dropped and no `o_done` is pulsed.
- **Start latency:** a start accepted at edge n gives `o_val=1` and `o_sop=1` after edge n, i.e. the first beat is visible in cycle n+1.
- **Throughput:** one beat per cycle while `i_rdy=1`.
- **Stalls:** while `o_val&&!i_rdy`, `o_dat`, `o_sop`, `o_eop` and `o_mod` are held stable. `o_val` never drops without a handshake.
- **Flags:** `o_busy` falls and `o_done` rises in the cycle after the eop handshake. A new start is accepted in that same cycle, because the state is already IDLE.

## Configuration
- **`PRBS_VEC_GEN_CSUM_EN` defined:**
  - Adds port `o_csum`: the running XOR of all emitted 32-bit-aligned words, with unused bytes as 0.
  - `o_csum` clears on accepted start.
  - `o_csum` is valid when `o_done` pulses and holds until the next start.
  - `o_csum` resets to 0.
- **Not defined:** the port and its logic are absent. All other behaviour is identical.

## Structure
- **Shared package:**
  - Function `xorshift32_step(logic [31:0])`.
  - Typedef `prbs_state_t` (enum IDLE/SEND).
  - Constant `PRBS_ZERO_SEED_SUB = 32'd1`.
- **Sub-module `prbs_unroll`:** combinational. Parameter NB; input state; outputs NB bytes and the next state. It is reused by the checker.

## Test plan
- **Reference bytes:** seed=1, len=2, DAT_BITS=64, `i_rdy=1` -> one beat with sop=eop=1, `o_dat[15:0]=16'h0121`, upper bytes 0, `o_mod=6`, `o_done` one cycle after.
- **Multi-beat:** seed=0, len=20, NB=8 -> identical to seed=1. 3 beats; sop on beat 0 only; eop on beat 2 with `o_mod=4`. Bytes match a software xorshift32 model.
- **Backpressure:** len=64 with random `i_rdy` (50%) -> 8 beats; data held stable across stalls; byte stream equal to the no-stall run.
- **Zero length and ignored start:** len=0 -> no `o_val`, `o_done` pulse next cycle. `i_start` pulsed during SEND -> ignored, byte count unchanged.
- **Reset mid-vector:** assert `i_rst` after beat 1 of 4 -> all outputs 0 next cycle, no `o_done`. A fresh start then reproduces beat 0 exactly.
- **Checksum (`PRBS_VEC_GEN_CSUM_EN`):** len=8, seed=1 -> `o_csum` equals the XOR of the two 32-bit words of the beat, valid at `o_done`.
